// File: rtl/kf_phase_sequencer.sv
// Kalman filter iteration sequencer: walks PREDICT, COV, GAIN, CORRECT for
// snapshotted per-phase lengths, with start/busy/done handshake, stall and abort.
module kf_phase_sequencer #(
   parameter int CNT_BITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                stall,
   input  logic [CNT_BITS-1:0] len_predict,
   input  logic [CNT_BITS-1:0] len_cov,
   input  logic [CNT_BITS-1:0] len_gain,
   input  logic [CNT_BITS-1:0] len_correct,
   output logic                busy,
   output logic [3:0]          phase_en,
   output logic [1:0]          phase_id,
   output logic [CNT_BITS-1:0] cnt,
   output logic                phase_last,
   output logic                done,
   output logic                aborted
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] len_in [4];
   logic [CNT_BITS-1:0] len_q  [4];
   logic [1:0]          phase_q, phase_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                done_d, aborted_d;
   logic                snap;
   logic [3:0]          nz_in, nz_q, nz_after;
   logic                first_vld, next_vld;
   logic [1:0]          first_idx, next_idx;

   // Lowest set bit of a 4-bit mask as {found, index}.
   function automatic logic [2:0] lowest_set(input logic [3:0] m);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   assign len_in[0] = len_predict;
   assign len_in[1] = len_cov;
   assign len_in[2] = len_gain;
   assign len_in[3] = len_correct;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nz_in[i] = |len_in[i];
         nz_q[i]  = |len_q[i];
      end
   end

   // Zero-length phases are masked out so the search lands directly on the next live phase.
   assign nz_after                = nz_q & (4'b1110 << phase_q);
   assign {first_vld, first_idx}  = lowest_set(nz_in);
   assign {next_vld, next_idx}    = lowest_set(nz_after);
   assign snap                    = (state_q == S_IDLE) && start && !abort;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      aborted_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (snap) begin
               if (first_vld) begin
                  state_d = S_RUN;
                  phase_d = first_idx;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d   = S_IDLE;
               phase_d   = 2'd0;
               cnt_d     = CNT_ZERO;
               aborted_d = 1'b1;
            end else if (!stall) begin
               if (cnt_q != len_q[phase_q]) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else if (next_vld) begin
                  phase_d = next_idx;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = S_FIN;
                  phase_d = 2'd0;
                  cnt_d   = CNT_ZERO;
               end
            end
         end
         S_FIN: begin
            state_d   = S_IDLE;
            aborted_d = abort;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = 2'd0;
            cnt_d   = CNT_ZERO;
         end
      endcase
      done_d = (state_d == S_FIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         phase_q  <= 2'd0;
         cnt_q    <= CNT_ZERO;
         busy     <= 1'b0;
         phase_en <= 4'b0000;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         busy     <= (state_d == S_RUN);
         phase_en <= (state_d == S_RUN) ? (4'b0001 << phase_d) : 4'b0000;
         done     <= done_d;
         aborted  <= aborted_d;
      end
   end

   // Length snapshot is held for the whole iteration; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (snap) begin
         for (int i = 0; i < 4; i++) len_q[i] <= len_in[i];
      end
   end

   assign phase_id   = phase_q;
   assign cnt        = cnt_q;
   assign phase_last = (|phase_en) && (cnt_q == len_q[phase_q]);

endmodule

// File: tb/tb_kf_phase_sequencer.sv
// Self-checking bench for kf_phase_sequencer: expected per-cycle output traces
// are queued when a scenario is launched and popped as the DUT runs.
module tb_kf_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       stall = 1'b0;
   logic [4:0] len_predict = '0;
   logic [4:0] len_cov = '0;
   logic [4:0] len_gain = '0;
   logic [4:0] len_correct = '0;
   logic       busy;
   logic [3:0] phase_en;
   logic [1:0] phase_id;
   logic [4:0] cnt;
   logic       phase_last;
   logic       done;
   logic       aborted;

   typedef struct packed {
      logic       busy;
      logic [3:0] pen;
      logic [1:0] pid;
      logic [4:0] cnt;
      logic       plast;
      logic       done;
      logic       aborted;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   kf_phase_sequencer #(.CNT_BITS(5)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
      .len_predict(len_predict), .len_cov(len_cov), .len_gain(len_gain),
      .len_correct(len_correct), .busy(busy), .phase_en(phase_en),
      .phase_id(phase_id), .cnt(cnt), .phase_last(phase_last),
      .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.busy = busy; o.pen = phase_en; o.pid = phase_id; o.cnt = cnt;
      o.plast = phase_last; o.done = done; o.aborted = aborted;
      return o;
   endfunction

   // Launches one iteration at edge 0. stall_m bit c drives stall during cycle c;
   // cut>0 drives abort (or rst) during that cycle; extra_start drives a stray start.
   task automatic run_case(input string name,
                           input logic [4:0] l0, input logic [4:0] l1,
                           input logic [4:0] l2, input logic [4:0] l3,
                           input logic [63:0] stall_m, input int cut,
                           input bit cut_rst, input int extra_start);
      logic [4:0] lens [4];
      obs_t tr [0:99];
      obs_t e, o;
      int c, last, nc;
      lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
      for (int k = 0; k < 100; k++) tr[k] = '0;
      c = 1;
      for (int p = 0; p < 4; p++) begin
         for (int b = 1; b <= int'(lens[p]); b++) begin
            e = '0;
            e.busy = 1'b1; e.pen = 4'(1 << p); e.pid = 2'(p);
            e.cnt = 5'(b); e.plast = (b == int'(lens[p]));
            tr[c] = e;
            while (c < 63 && stall_m[c]) begin
               c++;
               tr[c] = e;
            end
            c++;
         end
      end
      tr[c].done = 1'b1;
      last = c;
      if (cut > 0) begin
         for (int k = cut + 1; k <= last; k++) tr[k] = '0;
         tr[cut+1].aborted = !cut_rst;
         if (last < cut + 1) last = cut + 1;
      end
      nc = last + 3;
      for (int k = 1; k <= nc; k++) exp_q.push_back(tr[k]);

      len_predict = l0; len_cov = l1; len_gain = l2; len_correct = l3;
      start = 1'b1; stall = stall_m[0];
      @(posedge clk); #1;
      start = 1'b0;
      len_predict = ~l0; len_cov = ~l1; len_gain = ~l2; len_correct = ~l3;
      for (int cyc = 1; cyc <= nc; cyc++) begin
         stall = (cyc < 64) ? stall_m[cyc] : 1'b0;
         abort = (cyc == cut) && !cut_rst;
         rst   = (cyc == cut) && cut_rst;
         start = (cyc == extra_start);
         o = sample();
         e = exp_q.pop_front();
         n_checks++;
         if (o !== e)
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, o, e);
         else
            n_pass++;
         @(posedge clk); #1;
      end
      stall = 1'b0; abort = 1'b0; rst = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e, o;
      rst = 1'b1; start = 1'b1;
      len_predict = 5'd3; len_cov = 5'd3; len_gain = 5'd3; len_correct = 5'd3;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_q.push_back('0);
      o = sample(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL reset_hold: got %h expected %h", o, e);
      else n_pass++;
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back('0);
      o = sample(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL reset_release: got %h expected %h", o, e);
      else n_pass++;
   endtask

   task automatic test_idle_controls();
      obs_t e, o;
      len_predict = 5'd2; len_cov = 5'd2; len_gain = 5'd2; len_correct = 5'd2;
      abort = 1'b1; stall = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back('0);
      o = sample(); e = exp_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL idle_abort: got %h expected %h", o, e);
      else n_pass++;
      start = 1'b1; abort = 1'b1; stall = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back('0);
         o = sample(); e = exp_q.pop_front(); n_checks++;
         if (o !== e) $display("FAIL idle_start_abort %0d: got %h expected %h", k, o, e);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_nominal();
      run_case("nominal", 5'd2, 5'd3, 5'd1, 5'd2, 64'h0, 0, 1'b0, 0);
   endtask

   task automatic test_skip();
      run_case("skip", 5'd2, 5'd0, 5'd0, 5'd3, 64'h0, 0, 1'b0, 0);
      run_case("skip_stall_idle_fin", 5'd2, 5'd0, 5'd0, 5'd3, 64'h41, 0, 1'b0, 0);
   endtask

   task automatic test_stall();
      run_case("stall", 5'd2, 5'd3, 5'd1, 5'd2, 64'h30, 0, 1'b0, 0);
      run_case("stall_last", 5'd1, 5'd0, 5'd0, 5'd2, 64'h6, 0, 1'b0, 0);
   endtask

   task automatic test_abort();
      run_case("abort", 5'd2, 5'd3, 5'd1, 5'd2, 64'h0, 4, 1'b0, 0);
      run_case("restart", 5'd1, 5'd1, 5'd2, 5'd1, 64'h0, 0, 1'b0, 0);
      run_case("abort_fin", 5'd1, 5'd0, 5'd0, 5'd0, 64'h0, 2, 1'b0, 0);
   endtask

   task automatic test_zero_and_max();
      run_case("all_zero", 5'd0, 5'd0, 5'd0, 5'd0, 64'h0, 0, 1'b0, 0);
      run_case("max_len", 5'd31, 5'd0, 5'd0, 5'd0, 64'h0, 0, 1'b0, 0);
   endtask

   task automatic test_reset_mid_run();
      run_case("rst_mid", 5'd2, 5'd3, 5'd1, 5'd2, 64'h0, 3, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      run_case("start_busy", 5'd2, 5'd3, 5'd1, 5'd2, 64'h0, 0, 1'b0, 4);
      run_case("start_fin", 5'd2, 5'd3, 5'd1, 5'd2, 64'h0, 0, 1'b0, 9);
      run_case("b2b", 5'd0, 5'd2, 5'd0, 5'd1, 64'h0, 0, 1'b0, 0);
   endtask

   initial begin
      #1;
      test_reset();
      test_idle_controls();
      test_nominal();
      test_skip();
      test_stall();
      test_abort();
      test_zero_and_max();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kf_phase_sequencer.md
Name: kf_phase_sequencer

Overview:
Controller that sequences one Kalman filter iteration through four fixed phases in order: PREDICT(0), COV(1), GAIN(2), CORRECT(3). Each phase runs for a programmable number of active cycles, counted by an internal flexible counter. The block drives one-hot phase enables and a beat count to the shared filter datapath. It exposes a start/busy/done handshake to the top-level measurement loop, and provides stall and abort controls.

Parameters:
CNT_BITS, 5, width of each phase length and of the beat counter; max phase length 2^CNT_BITS-1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  request one filter iteration; sampled in IDLE only.
abort  in  1  cancel the iteration in progress.
stall  in  1  datapath back-pressure; freezes the sequencer while high.
len_predict  in  CNT_BITS  active cycles for phase 0.
len_cov  in  CNT_BITS  active cycles for phase 1.
len_gain  in  CNT_BITS  active cycles for phase 2.
len_correct  in  CNT_BITS  active cycles for phase 3.
busy  out  1  iteration in progress (RUN state).
phase_en  out  4  one-hot enable for the current phase; all zero outside RUN.
phase_id  out  2  encoded current phase; 0 outside RUN.
cnt  out  CNT_BITS  beat within phase, 1..len; 0 outside RUN.
phase_last  out  1  high when phase_en!=0 and cnt==latched length (combinational).
done  out  1  one-cycle pulse when an iteration completes normally.
aborted  out  1  one-cycle pulse when an iteration is cancelled.

Behaviour:
- Reset: synchronous. On the clk edge with rst=1, the state goes to IDLE and busy, phase_en, phase_id, cnt, done and aborted all become 0. rst overrides every other input.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: busy=0, done=1 for exactly one cycle, then IDLE.
- All outputs except phase_last are registered.
- IDLE, start=1, abort=0:
  - Snapshot all four lengths into internal registers. Later input changes have no effect until the next start.
  - Select the first phase with a nonzero snapshot length. Next cycle: RUN, that phase's phase_en bit=1, cnt=1.
  - If all four lengths are 0, go directly to FIN. done pulses on the following cycle and busy never rises.
- Latency: start sampled at edge k; busy and phase_en are valid from cycle k+1.
- RUN, stall=0:
  - If cnt < len, cnt increments.
  - If cnt == len, advance to the next phase index with a nonzero length and set cnt=1.
  - If no such phase remains, go to FIN and clear phase_en, phase_id and cnt.
  - Phases with length 0 are skipped with no idle cycle.
  - Each phase is active for exactly len non-stalled cycles.
  - Total RUN cycles = sum of lengths + number of stalled cycles.
- RUN, stall=1: cnt, phase and state hold. phase_last may remain high; the datapath qualifies it with !stall. stall has no effect in IDLE or FIN.
- abort=1 in RUN or FIN (checked before stall or advance): next cycle IDLE, aborted=1 for one cycle, done not asserted, all phase outputs 0. abort in IDLE is ignored and aborted stays 0.
- start while in RUN or FIN is ignored; it is not queued.
- start and abort together in IDLE: abort wins and the state stays IDLE.
- cnt never exceeds the latched length. With length = 2^CNT_BITS-1, cnt reaches all-ones and then moves to the next phase with no wrap to 0.
- phase_en is always one-hot in RUN and always zero outside RUN. phase_id always matches phase_en.

Test Plan:
1. CNT_BITS=5, lengths 2,3,1,2, start at edge 0, stall=0 -> phase_en=0001 in cycles 1-2, 0010 in cycles 3-5, 0100 in cycle 6, 1000 in cycles 7-8. done=1 and busy=0 in cycle 9. phase_last high in cycles 2, 5, 6 and 8.
2. Lengths 2,0,0,3 -> phase 0 in cycles 1-2, phase 3 in cycles 3-5, done in cycle 6. phase_en never shows 0010 or 0100.
3. Lengths 2,3,1,2 with stall=1 in cycles 4-5 -> cnt holds at 2 during the stall, phase 1 ends in cycle 7, done in cycle 11.
4. abort in cycle 4 of scenario 1 -> cycle 5: IDLE, aborted=1, phase_en=0000, no done pulse. A start at cycle 6 runs a full iteration with lengths re-snapshotted.
5. All lengths 0 -> busy stays 0, done=1 in cycle 1. Also: lengths 31,0,0,0 -> cnt counts 1..31 with no wrap, done in cycle 32.
6. rst asserted in cycle 3 of scenario 1, plus start asserted in cycle 4 while busy from a prior start -> reset: all outputs 0 at the next edge, no done. start ignored while busy: a single done is produced at the original time.
